// File: rtl/snitch_dma_twod_splitter.sv
// Buffers 2D DMA transfer requests and unrolls each one into a stream of 1D bursts,
// tagging the final burst of every request with a last flag.
package snitch_dma_twod_splitter_pkg;

  localparam int unsigned AddrWidth = 64;
  localparam int unsigned IdWidth   = 6;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] src;
    logic [AddrWidth-1:0] dst;
    logic [AddrWidth-1:0] num_bytes;
    logic [3:0]           cache_src;
    logic [3:0]           cache_dst;
    logic [AddrWidth-1:0] stride_src;
    logic [AddrWidth-1:0] stride_dst;
    logic [AddrWidth-1:0] num_repetitions;
    logic [1:0]           burst_src;
    logic [1:0]           burst_dst;
    logic                 decouple_rw;
    logic                 deburst;
    logic                 is_twod;
  } twod_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] src;
    logic [AddrWidth-1:0] dst;
    logic [AddrWidth-1:0] num_bytes;
    logic [3:0]           cache_src;
    logic [3:0]           cache_dst;
    logic [1:0]           burst_src;
    logic [1:0]           burst_dst;
    logic                 decouple_rw;
    logic                 deburst;
    logic                 serialize;
  } burst_req_t;

endpackage

module snitch_dma_twod_splitter #(
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned IdWidth      = 6,
  parameter int unsigned ReqFifoDepth = 3,
  parameter type twod_req_t  = snitch_dma_twod_splitter_pkg::twod_req_t,
  parameter type burst_req_t = snitch_dma_twod_splitter_pkg::burst_req_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  twod_req_t  twod_req_i,
  input  logic       twod_req_valid_i,
  output logic       twod_req_ready_o,
  output burst_req_t burst_req_o,
  output logic       burst_req_valid_o,
  input  logic       burst_req_ready_i,
  output logic       twod_req_last_o,
  output logic       busy_o
);

  localparam int unsigned PtrW = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(ReqFifoDepth + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               r_state, w_state_d;
  twod_req_t            r_mem [ReqFifoDepth];
  logic [PtrW-1:0]      r_wptr, r_rptr;
  logic [CntW-1:0]      r_count;
  burst_req_t           r_burst;
  logic [AddrWidth-1:0] r_stride_src, r_stride_dst, r_reps;

  logic                 w_empty, w_full, w_push, w_pop, w_run, w_hs, w_last_rep;
  twod_req_t            w_head;
  logic [IdWidth-1:0]   w_head_id;

  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(ReqFifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CntW'(ReqFifoDepth));
  assign w_push     = twod_req_valid_i && !w_full;
  assign w_head     = r_mem[r_rptr];
  assign w_head_id  = w_head.id;
  assign w_run      = (r_state == RUN);
  assign w_hs       = w_run && burst_req_ready_i;
  assign w_last_rep = (r_reps == AddrWidth'(1));
  // Reload on the final handshake so consecutive requests stream without a bubble.
  assign w_pop      = !w_empty && (!w_run || (w_hs && w_last_rep));

  assign twod_req_ready_o = !w_full;
  assign busy_o           = !w_empty || w_run;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= twod_req_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_d = RUN;
      RUN:     if (w_hs && w_last_rep && w_empty) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    burst_req_valid_o = 1'b0;
    burst_req_o       = '0;
    twod_req_last_o   = 1'b0;
    if (r_state == RUN) begin
      burst_req_valid_o = 1'b1;
      burst_req_o       = r_burst;
      twod_req_last_o   = w_last_rep;
    end
  end

  // r_burst holds the outgoing burst; its src/dst fields act as the walking addresses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_burst      <= '0;
      r_stride_src <= '0;
      r_stride_dst <= '0;
      r_reps       <= '0;
    end else if (w_pop) begin
      r_burst.id          <= w_head_id;
      r_burst.src         <= w_head.src;
      r_burst.dst         <= w_head.dst;
      r_burst.num_bytes   <= w_head.num_bytes;
      r_burst.cache_src   <= w_head.cache_src;
      r_burst.cache_dst   <= w_head.cache_dst;
      r_burst.burst_src   <= w_head.burst_src;
      r_burst.burst_dst   <= w_head.burst_dst;
      r_burst.decouple_rw <= w_head.decouple_rw;
      r_burst.deburst     <= w_head.deburst;
      r_burst.serialize   <= 1'b0;
      r_stride_src        <= w_head.stride_src;
      r_stride_dst        <= w_head.stride_dst;
      r_reps              <= (w_head.is_twod && w_head.num_repetitions != '0)
                             ? w_head.num_repetitions : AddrWidth'(1);
    end else if (w_hs && !w_last_rep) begin
      r_burst.src <= r_burst.src + r_stride_src;
      r_burst.dst <= r_burst.dst + r_stride_dst;
      r_reps      <= r_reps - AddrWidth'(1);
    end
  end

endmodule

// File: tb/tb_snitch_dma_twod_splitter.sv
// Directed and randomized bench for the 2D splitter, checked against a queue of bursts
// expanded from each accepted request.
module tb_snitch_dma_twod_splitter;
  import snitch_dma_twod_splitter_pkg::*;

  typedef struct packed {
    burst_req_t b;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  twod_req_t  req;
  logic       req_valid, req_ready;
  burst_req_t burst;
  logic       bvalid, bready, blast, busy;
  logic       rand_ready;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  snitch_dma_twod_splitter #(
    .AddrWidth   (64),
    .IdWidth     (6),
    .ReqFifoDepth(3)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .twod_req_i       (req),
    .twod_req_valid_i (req_valid),
    .twod_req_ready_o (req_ready),
    .burst_req_o      (burst),
    .burst_req_valid_o(bvalid),
    .burst_req_ready_i(bready),
    .twod_req_last_o  (blast),
    .busy_o           (busy)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a request expands into n bursts with linearly advancing addresses.
  function automatic void model_push(input twod_req_t r);
    longint unsigned n;
    exp_t e;
    n = (r.is_twod && r.num_repetitions != 0) ? r.num_repetitions : 64'd1;
    for (longint unsigned k = 0; k < n; k++) begin
      e.b.id          = r.id;
      e.b.src         = r.src + k * r.stride_src;
      e.b.dst         = r.dst + k * r.stride_dst;
      e.b.num_bytes   = r.num_bytes;
      e.b.cache_src   = r.cache_src;
      e.b.cache_dst   = r.cache_dst;
      e.b.burst_src   = r.burst_src;
      e.b.burst_dst   = r.burst_dst;
      e.b.decouple_rw = r.decouple_rw;
      e.b.deburst     = r.deburst;
      e.b.serialize   = 1'b0;
      e.last          = (k == n - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic twod_req_t rnd_req();
    twod_req_t r;
    r.id              = 6'($urandom);
    r.src             = {$urandom, $urandom};
    r.dst             = {$urandom, $urandom};
    r.num_bytes       = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 4096));
    r.cache_src       = 4'($urandom);
    r.cache_dst       = 4'($urandom);
    r.stride_src      = {$urandom, $urandom};
    r.stride_dst      = {$urandom, $urandom};
    r.num_repetitions = 64'($urandom_range(0, 4));
    r.burst_src       = 2'($urandom);
    r.burst_dst       = 2'($urandom);
    r.decouple_rw     = 1'($urandom);
    r.deburst         = 1'($urandom);
    r.is_twod         = 1'($urandom);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) bready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input twod_req_t r);
    int unsigned waited = 0;
    req       = r;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    chk("push_timeout", waited < 200, 1);
    if (waited < 200) begin
      step();
      model_push(r);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || bvalid) && n < 1000) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 1000, 1);
    chk("drain_busy", busy, 0);
  endtask

  // Output monitor: checks accepted bursts against the model and holds under stall.
  initial begin
    exp_t       e;
    logic       hold_v = 1'b0;
    burst_req_t hold_b;
    logic       hold_l;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("stall_valid", bvalid, 1);
          chk("stall_burst", burst, hold_b);
          chk("stall_last", blast, hold_l);
        end
        if (bvalid && bready) begin
          chk("unexpected_burst", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("burst_fields", burst, e.b);
            chk("burst_last", blast, e.last);
          end
        end
        hold_v = bvalid && !bready;
        hold_b = burst;
        hold_l = blast;
      end
    end
  end

  initial begin
    twod_req_t r;
    rst_n      = 1'b0;
    req        = '0;
    req_valid  = 1'b0;
    bready     = 1'b0;
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", bvalid, 0);
    chk("rst_burst", burst, '0);
    chk("rst_last", blast, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // 1D pass-through with latency check
    r = rnd_req();
    r.src = 64'h1000; r.dst = 64'h2000; r.num_bytes = 64'd64;
    r.is_twod = 1'b0; r.num_repetitions = 64'd5;
    bready = 1'b1;
    push(r);
    chk("lat_pop_cycle", bvalid, 0);
    chk("lat_busy", busy, 1);
    step();
    chk("lat_valid", bvalid, 1);
    chk("1d_last", blast, 1);
    drain();

    // 2D unroll
    r = rnd_req();
    r.src = 64'h100; r.dst = 64'h800; r.stride_src = 64'h40; r.stride_dst = 64'h80;
    r.is_twod = 1'b1; r.num_repetitions = 64'd3;
    push(r);
    drain();

    // Back-pressure on burst 2
    push(r);
    step();
    chk("bp_first_valid", bvalid, 1);
    step();
    bready = 1'b0;
    chk("bp_burst2_src", burst.src, 64'h140);
    repeat (5) step();
    bready = 1'b1;
    drain();

    // Edge: zero repetitions, negative stride wrap
    r = rnd_req();
    r.is_twod = 1'b1; r.num_repetitions = 64'd0;
    push(r);
    drain();
    r = rnd_req();
    r.src = 64'h20; r.stride_src = 64'hFFFF_FFFF_FFFF_FFC0;
    r.is_twod = 1'b1; r.num_repetitions = 64'd2;
    bready = 1'b0;
    push(r);
    step();
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("neg_stride_src", burst.src, 64'hFFFF_FFFF_FFFF_FFE0);
    chk("neg_stride_last", blast, 1);
    bready = 1'b1;
    drain();

    // Fill the buffer under back-pressure, then release
    bready = 1'b0;
    r = rnd_req(); r.is_twod = 1'b1; r.num_repetitions = 64'd2; push(r);
    r = rnd_req(); r.is_twod = 1'b0; push(r);
    r = rnd_req(); r.is_twod = 1'b1; r.num_repetitions = 64'd3; push(r);
    chk("full_ready_before", req_ready, 1);
    r = rnd_req(); r.is_twod = 1'b1; r.num_repetitions = 64'd2; push(r);
    chk("full_ready_low", req_ready, 0);
    step();
    chk("full_ready_held", req_ready, 0);
    bready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("no_bubble", bvalid, 1);
      step();
    end
    chk("full_done_valid", bvalid, 0);
    drain();

    // Reset during burst 2 of 3 with a second request buffered
    r = rnd_req(); r.is_twod = 1'b1; r.num_repetitions = 64'd3; push(r);
    r = rnd_req(); push(r);
    step();
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", bvalid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", req_ready, 1);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rstmid_no_stale", bvalid, 0);
    end
    chk("rstmid_idle_busy", busy, 0);

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 25; i++) push(rnd_req());
    drain();
    rand_ready = 1'b0;
    chk("model_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
